pll_reconfig_seq: RTL



---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/pll_reconfig_seq_if.sv | 11 +
 rtl/pll_reconfig_seq_sync_2ff.sv | 11 +
 rtl/pll_reconfig_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, code width and default rPLL divider codes for the PLL sequencer
package pll_seq_pkg;
  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] DEFAULT_IDSEL = 6'h3E;
  localparam logic [SEL_W-1:0] DEFAULT_FBDSEL = 6'h3C;
  localparam logic [SEL_W-1:0] DEFAULT_ODSEL = 6'h3C;
  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, INIT_WAIT, READY, ERROR} state_e;
  typedef struct packed {
    logic [SEL_W-1:0] idsel;
    logic [SEL_W-1:0] fbdsel;
    logic [SEL_W-1:0] odsel;
  } codes_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pll_reconfig_seq_if.sv
// pll_reconfig_seq_if: runtime PLL reconfiguration request/acknowledge channel
interface pll_reconfig_seq_if;
  import pll_seq_pkg::*;
  logic cfg_req;
  logic cfg_ack;
  logic [SEL_W-1:0] cfg_idsel;
  logic [SEL_W-1:0] cfg_fbdsel;
  logic [SEL_W-1:0] cfg_odsel;
  modport master(output cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel, input cfg_ack);
  modport slave(input cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel, output cfg_ack);
endinterface

// File: rtl/pll_reconfig_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk) s_q <= rst ? 2'b00 : {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: rPLL reset/code sequencer with qualified lock, PSRAM power-up hold and retries.
// Define PLL_LOCK_RECOVERY_EN to rerun the sequence automatically when lock drops while READY.
module pll_reconfig_seq import pll_seq_pkg::*; #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int PSRAM_INIT_CYCLES = 4050,
  parameter int MAX_RETRIES = 3,
  parameter logic [SEL_W-1:0] DEF_IDSEL = DEFAULT_IDSEL,
  parameter logic [SEL_W-1:0] DEF_FBDSEL = DEFAULT_FBDSEL,
  parameter logic [SEL_W-1:0] DEF_ODSEL = DEFAULT_ODSEL
) (
  input  logic clk,
  input  logic rst,
  pll_reconfig_seq_if.slave cfg,
  input  logic pll_lock_i,
  output logic pll_reset_o,
  output logic [SEL_W-1:0] pll_idsel_o,
  output logic [SEL_W-1:0] pll_fbdsel_o,
  output logic [SEL_W-1:0] pll_odsel_o,
  output logic sys_rst_o,
  output logic busy_o,
  output logic ready_o,
  output logic err_o,
  output logic lock_lost_o
);
  localparam int MAX_CYC = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES), max2(LOCK_STABLE_CYCLES, PSRAM_INIT_CYCLES));
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1) > 2 ? $clog2(MAX_RETRIES + 1) : 2;
  localparam logic [CW-1:0] HOLD_LD = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LD = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LD = CW'(PSRAM_INIT_CYCLES - 1);
  localparam codes_t DEF_CODES = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  codes_t pend_q, pend_d, code_q, code_d;
  logic lost_q, lost_d, ack_q, ack_d, lock_s, fail;
  sync_2ff u_lock_sync (.clk(clk), .rst(rst), .d_i(pll_lock_i), .q_o(lock_s));
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q inside {READY, ERROR}) ? cnt_q : cnt_q - CW'(1);
    retry_d = retry_q;
    pend_d = pend_q;
    code_d = (state_q == RST_PLL && cnt_q == HOLD_LD) ? pend_q : code_q;
    lost_d = lost_q;
    ack_d = 1'b0;
    fail = 1'b0;
    case (state_q)
      RST_PLL: if (cnt_q == '0) begin
        state_d = WAIT_LOCK;
        cnt_d = TMO_LD;
      end
      WAIT_LOCK: if (lock_s) begin
        state_d = STABLE;
        cnt_d = STB_LD;
      end else fail = cnt_q == '0;
      STABLE: if (!lock_s) fail = 1'b1;
      else if (cnt_q == '0) begin
        state_d = INIT_WAIT;
        cnt_d = INIT_LD;
      end
      INIT_WAIT: if (!lock_s) fail = 1'b1;
      else if (cnt_q == '0) state_d = READY;
      default: ;
    endcase
    if (fail) begin
      retry_d = retry_q + RW'(1);
      state_d = (retry_d == RW'(MAX_RETRIES)) ? ERROR : RST_PLL;
      cnt_d = HOLD_LD;
    end
    if (state_q == READY && !lock_s) begin
      lost_d = 1'b1;
`ifdef PLL_LOCK_RECOVERY_EN
      state_d = RST_PLL;
      cnt_d = HOLD_LD;
      retry_d = '0;
`endif
    end
    // an accepted request overrides any lock-drop handling in the same cycle
    if ((state_q == READY || state_q == ERROR) && cfg.cfg_req) begin
      pend_d = {cfg.cfg_idsel, cfg.cfg_fbdsel, cfg.cfg_odsel};
      ack_d = 1'b1;
      state_d = RST_PLL;
      cnt_d = HOLD_LD;
      retry_d = '0;
      lost_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_PLL;
      cnt_q <= HOLD_LD;
      retry_q <= '0;
      pend_q <= DEF_CODES;
      code_q <= DEF_CODES;
      lost_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      pend_q <= pend_d;
      code_q <= code_d;
      lost_q <= lost_d;
      ack_q <= ack_d;
    end
  end
  assign pll_reset_o = state_q == RST_PLL || state_q == ERROR;
  assign sys_rst_o = state_q != READY;
  assign busy_o = !(state_q == READY || state_q == ERROR);
  assign ready_o = state_q == READY;
  assign err_o = state_q == ERROR;
  assign lock_lost_o = lost_q;
  assign cfg.cfg_ack = ack_q;
  assign {pll_idsel_o, pll_fbdsel_o, pll_odsel_o} = code_q;
endmodule
